// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, FIFO depth and ingress FSM encoding for the UART receive FIFO
package uart_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int FIFO_DEPTH = 1 << DEF_ADDR_W;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UNLOAD  = 2'd1,
        CAPTURE = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_mem_16x8.sv
// fifo_mem_16x8: dual-port register array, sync write; registered read, or combinational
// read when UART_RX_FIFO_FWFT_EN is defined
module fifo_mem_16x8 import uart_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
`ifdef UART_RX_FIFO_FWFT_EN
    logic unused_fwft;
    assign unused_fwft = rst ^ re;
    assign rdata = mem[raddr];
`else
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
`endif
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: unloads bytes from the UART receiver into a circular FIFO for the consumer;
// UART_RX_FIFO_FWFT_EN selects first-word-fall-through reads
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [DATA_W-1:0] rx_data,
    output logic              uld_rx_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_count
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(2**ADDR_W);
    state_t            state;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, next_count;
    logic              push, pop;
    assign push = state == CAPTURE;
    assign pop = rd_en && !fifo_empty;
    assign fifo_count = count;
    always_comb begin
        next_count = push && !pop ? count + (ADDR_W+1)'(1) :
                     pop && !push ? count - (ADDR_W+1)'(1) : count;
    end
    // Full is only consulted in IDLE, so a slot is always free by CAPTURE
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state       <= IDLE;
            uld_rx_data <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_empty && !fifo_full) begin
                        uld_rx_data <= 1'b1;
                        state       <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    uld_rx_data <= 1'b0;
                    state       <= CAPTURE;
                end
                default: begin
                    uld_rx_data <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge rxclk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            count      <= next_count;
            fifo_empty <= next_count == '0;
            fifo_full  <= next_count == FULL_CNT;
        end
    end
`ifdef UART_RX_FIFO_FWFT_EN
    assign rd_valid = !fifo_empty;
`else
    always_ff @(posedge rxclk) begin
        if (reset) rd_valid <= 1'b0;
        else rd_valid <= pop;
    end
`endif
    fifo_mem_16x8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk   (rxclk),
        .rst   (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );
endmodule
